// File: rtl/magic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : magic_pkg
// Brief    : Shared opcodes, instruction layout and FSM states for the MAGIC
//            NOR/NOT sequential evaluation engine.
// Revision : 1.0
// ============================================================================
package magic_pkg;

    localparam int C_NCELLS     = 32;
    localparam int C_PROG_DEPTH = 64;
    localparam int C_CW         = $clog2(C_NCELLS);
    localparam int C_AW         = $clog2(C_PROG_DEPTH);

    typedef enum logic [1:0] {
        OP_INIT = 2'b00,
        OP_NOT  = 2'b01,
        OP_NOR  = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [C_CW-1:0]  dst;
        logic [C_CW-1:0]  srca;
        logic [C_CW-1:0]  srcb;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Range check on a zero-extended index; avoids constant-compare warnings
    // when the index field exactly spans the cell array.
    function automatic logic idx_ok(input logic [31:0] idx, input int unsigned n);
        return (idx < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/magic_nor_executor_if.sv
`default_nettype none
// ============================================================================
// Module   : magic_nor_executor_if
// Brief    : Program-load / run-control / result bundle of the MAGIC engine.
// Revision : 1.0
// ============================================================================
interface magic_nor_executor_if #(
    parameter int NCELLS     = 32,
    parameter int PROG_DEPTH = 64
);
    localparam int CW = $clog2(NCELLS);
    localparam int AW = $clog2(PROG_DEPTH);

    logic                prog_we;
    logic [AW-1:0]       prog_addr;
    logic [2+3*CW-1:0]   prog_wdata;
    logic [AW:0]         prog_len;
    logic                start;
    logic [NCELLS-1:0]   in_bits;

    logic                busy;
    logic                done;
    logic                err;
    logic [AW-1:0]       err_pc;
    logic [NCELLS-1:0]   cells;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, start, in_bits,
        input  busy, done, err, err_pc, cells
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, start, in_bits,
        output busy, done, err, err_pc, cells
    );
endinterface
`default_nettype wire

// File: rtl/magic_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : magic_prog_mem
// Brief    : Instruction RAM, one write port and one synchronous read port.
// Revision : 1.0
// ============================================================================
module magic_prog_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 17,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents deliberately survive rst_n so a program outlives a run abort.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/magic_nor_executor.sv
`default_nettype none
// ============================================================================
// Module   : magic_nor_executor
// Brief    : Replays a NOR/NOT-mapped netlist one MAGIC init/evaluate step at a
//            time on a modelled memristor array, trapping illegal operations.
// Revision : 1.0
// ============================================================================
module magic_nor_executor
    import magic_pkg::*;
#(
    parameter int NCELLS     = 32,
    parameter int PROG_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    magic_nor_executor_if.slave     bus
);

    localparam int CW = $clog2(NCELLS);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int IW = 2 + 3*CW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(PROG_DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    state_e             r_state;
    logic [NCELLS-1:0]  r_cells;
    logic [NCELLS-1:0]  r_init;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      r_err_pc;
    logic [AW:0]        r_len;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [IW-1:0]      w_rdata;
    op_e                w_op;
    logic [CW-1:0]      w_dst;
    logic [CW-1:0]      w_srca;
    logic [CW-1:0]      w_srcb;
    logic               w_dst_ok;
    logic               w_a_ok;
    logic               w_b_ok;
    logic               w_illegal;
    logic               w_new_bit;
    logic               w_last;
    logic [AW:0]        w_len_clamp;
    logic               w_mem_we;
    logic               w_mem_re;

    assign w_mem_we = bus.prog_we & ~r_busy;
    assign w_mem_re = (r_state == S_FETCH);

    magic_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (IW),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_wdata),
        .i_re    (w_mem_re),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    assign w_op   = op_e'(w_rdata[IW-1 -: 2]);
    assign w_dst  = w_rdata[3*CW-1 -: CW];
    assign w_srca = w_rdata[2*CW-1 -: CW];
    assign w_srcb = w_rdata[CW-1:0];

    assign w_dst_ok = idx_ok(32'(w_dst),  NCELLS);
    assign w_a_ok   = idx_ok(32'(w_srca), NCELLS);
    assign w_b_ok   = idx_ok(32'(w_srcb), NCELLS);

    assign w_last      = ({1'b0, r_pc} == (r_len - C_ONE));
    assign w_len_clamp = (bus.prog_len > C_DEPTH) ? C_DEPTH : bus.prog_len;

    // MAGIC legality: evaluated dst must be freshly initialised and never
    // alias one of its own operands.
    always_comb begin
        w_illegal = 1'b0;
        w_new_bit = 1'b0;
        case (w_op)
            OP_INIT: begin
                w_illegal = !w_dst_ok;
                w_new_bit = 1'b1;
            end
            OP_NOT: begin
                w_illegal = !w_dst_ok || !w_a_ok || !r_init[w_dst] ||
                            (w_dst == w_srca);
                w_new_bit = r_cells[w_dst] & ~r_cells[w_srca];
            end
            OP_NOR: begin
                w_illegal = !w_dst_ok || !w_a_ok || !w_b_ok || !r_init[w_dst] ||
                            (w_dst == w_srca) || (w_dst == w_srcb);
                w_new_bit = r_cells[w_dst] & ~(r_cells[w_srca] | r_cells[w_srcb]);
            end
            default: begin
                w_illegal = 1'b0;
                w_new_bit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cells  <= '0;
            r_init   <= '0;
            r_pc     <= '0;
            r_err_pc <= '0;
            r_len    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cells  <= bus.in_bits;
                        r_init   <= '0;
                        r_pc     <= '0;
                        r_err    <= 1'b0;
                        r_err_pc <= '0;
                        r_len    <= w_len_clamp;
                        r_busy   <= 1'b1;
                        r_state  <= (bus.prog_len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_illegal) begin
                        r_err    <= 1'b1;
                        r_err_pc <= r_pc;
                        r_state  <= S_DONE;
                    end else begin
                        if (w_op != OP_HALT) begin
                            r_cells[w_dst] <= w_new_bit;
                            r_init[w_dst]  <= (w_op == OP_INIT);
                        end
                        if ((w_op == OP_HALT) || w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.err_pc = r_err_pc;
    assign bus.cells  = r_cells;

endmodule
`default_nettype wire

// File: tb/tb_magic_nor_executor.sv
`default_nettype none
// ============================================================================
// Module   : tb_magic_nor_executor
// Brief    : Directed and randomized bench with a per-instruction reference
//            model of the MAGIC engine.
// Revision : 1.0
// ============================================================================
module tb_magic_nor_executor;
    import magic_pkg::*;

    localparam int NC = C_NCELLS;
    localparam int PD = C_PROG_DEPTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    magic_nor_executor_if #(.NCELLS(NC), .PROG_DEPTH(PD)) bus ();

    magic_nor_executor #(.NCELLS(NC), .PROG_DEPTH(PD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks = 0;
    int     errors = 0;
    instr_t prog [PD];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input op_e op, input int d, input int a, input int b);
        instr_t t;
        t.op   = op;
        t.dst  = C_CW'(d);
        t.srca = C_CW'(a);
        t.srcb = C_CW'(b);
        return t;
    endfunction

    task automatic load(input int idx, input instr_t ins);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = C_AW'(idx);
        bus.prog_wdata = ins;
        @(posedge clk); #1;
        bus.prog_we    = 1'b0;
        prog[idx]      = ins;
    endtask

    // Plain sequential interpretation of the stored program.
    task automatic model_run(input int len_in, input logic [NC-1:0] bits,
                             output logic [NC-1:0] ec, output logic eerr,
                             output int epc, output int elat);
        bit ini [NC];
        int len, nexec, d, a, b;
        ec = bits; eerr = 1'b0; epc = 0; nexec = 0;
        for (int i = 0; i < NC; i++) ini[i] = 1'b0;
        len = (len_in > PD) ? PD : len_in;
        for (int p = 0; p < len; p++) begin
            d = int'(prog[p].dst); a = int'(prog[p].srca); b = int'(prog[p].srcb);
            nexec++;
            if (prog[p].op == OP_HALT) break;
            if (prog[p].op == OP_INIT) begin
                if (d >= NC) begin eerr = 1'b1; epc = p; break; end
                ec[d] = 1'b1; ini[d] = 1'b1;
            end else begin
                if (d >= NC || a >= NC || !ini[d] || d == a ||
                    (prog[p].op == OP_NOR && (b >= NC || d == b))) begin
                    eerr = 1'b1; epc = p; break;
                end
                if (prog[p].op == OP_NOT) ec[d] = ec[d] & ~ec[a];
                else                      ec[d] = ec[d] & ~(ec[a] | ec[b]);
                ini[d] = 1'b0;
            end
        end
        elat = (len_in == 0) ? 1 : 2*nexec + 1;
    endtask

    task automatic run(input int len, input logic [NC-1:0] bits, output int lat);
        bus.prog_len = (C_AW+1)'(len);
        bus.in_bits  = bits;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        lat = 0;
        while (!bus.done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string tag, input int len, input logic [NC-1:0] bits);
        logic [NC-1:0] ec;
        logic          eerr;
        int            epc, elat, lat;
        model_run(len, bits, ec, eerr, epc, elat);
        run(len, bits, lat);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_cells"}, bus.cells, ec);
        check({tag, "_err"}, bus.err, eerr);
        if (eerr) check({tag, "_err_pc"}, bus.err_pc, epc);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic load_half_adder();
        load(0,  mk(OP_INIT, 2, 0, 0)); load(1,  mk(OP_NOT, 2, 1, 0));
        load(2,  mk(OP_INIT, 3, 0, 0)); load(3,  mk(OP_NOT, 3, 0, 0));
        load(4,  mk(OP_INIT, 4, 0, 0)); load(5,  mk(OP_NOR, 4, 2, 0));
        load(6,  mk(OP_INIT, 5, 0, 0)); load(7,  mk(OP_NOR, 5, 1, 3));
        load(8,  mk(OP_INIT, 6, 0, 0)); load(9,  mk(OP_NOR, 6, 2, 3));
        load(10, mk(OP_INIT, 7, 0, 0)); load(11, mk(OP_NOR, 7, 5, 4));
        load(12, mk(OP_INIT, 8, 0, 0)); load(13, mk(OP_NOT, 8, 7, 0));
    endtask

    initial begin
        logic [NC-1:0] bits, ec;
        logic          eerr, a, b, saw_done;
        int            epc, elat, lat, len;
        op_e           op;

        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
        bus.prog_len = '0;  bus.start = 1'b0;   bus.in_bits = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cells",  bus.cells,  '0);
        check("reset_busy",   bus.busy,   1'b0);
        check("reset_done",   bus.done,   1'b0);
        check("reset_err",    bus.err,    1'b0);
        check("reset_err_pc", bus.err_pc, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Half adder, all four input combinations.
        load_half_adder();
        for (int k = 0; k < 4; k++) begin
            a = k[0]; b = k[1];
            bits = $urandom;
            bits[0] = a; bits[1] = b;
            run_and_check("half_adder", 14, bits);
            check("ha_and", bus.cells[6], a & b);
            check("ha_xor", bus.cells[8], a ^ b);
        end

        // NOR into never-initialised dst at pc=3.
        load(0, mk(OP_INIT, 2, 0, 0)); load(1, mk(OP_NOT, 2, 1, 0));
        load(2, mk(OP_INIT, 3, 0, 0)); load(3, mk(OP_NOR, 5, 0, 1));
        load(4, mk(OP_INIT, 6, 0, 0)); load(5, mk(OP_INIT, 7, 0, 0));
        run_and_check("uninit_dst", 6, 32'h0000_0003);
        check("uninit_err",    bus.err,    1'b1);
        check("uninit_err_pc", bus.err_pc, 3);

        // In-place NOR: dst aliases srcb.
        load(0, mk(OP_INIT, 4, 0, 0)); load(1, mk(OP_NOR, 4, 0, 4));
        run_and_check("inplace", 2, 32'h0000_0000);
        check("inplace_cell4", bus.cells[4], 1'b1);
        check("inplace_err",   bus.err,      1'b1);

        // HALT at pc=1 with a longer program length.
        load(0, mk(OP_INIT, 9, 0, 0)); load(1, mk(OP_HALT, 0, 0, 0));
        for (int i = 2; i < 10; i++) load(i, mk(OP_INIT, 10 + i, 0, 0));
        bits = $urandom;
        bits[9] = 1'b0;
        run_and_check("halt", 10, bits);

        // Empty program.
        bits = $urandom;
        run_and_check("len0", 0, bits);
        check("len0_cells", bus.cells, bits);

        // Length beyond depth is clamped.
        for (int i = 0; i < PD; i++) load(i, mk(OP_INIT, int'($urandom_range(0, NC-1)), 0, 0));
        run_and_check("clamp", 100, 32'h0);

        // Random programs biased toward legal sequences.
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: op = OP_INIT;
                    4, 5, 6:    op = OP_NOR;
                    7, 8:       op = OP_NOT;
                    default:    op = OP_HALT;
                endcase
                load(i, mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7))));
            end
            run_and_check("random", len, $urandom);
        end

        // Reset asserted during EXEC aborts with no done pulse.
        load_half_adder();
        bus.prog_len = 7'd14; bus.in_bits = 32'h3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_cells",  bus.cells,  '0);
        check("abort_busy",   bus.busy,   1'b0);
        check("abort_done",   bus.done,   1'b0);
        check("abort_err",    bus.err,    1'b0);
        check("abort_err_pc", bus.err_pc, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            saw_done |= bus.done;
        end
        check("abort_no_done", saw_done, 1'b0);

        // Writes and starts while busy must be dropped.
        model_run(14, 32'h3, ec, eerr, epc, elat);
        bus.prog_len = 7'd14; bus.in_bits = 32'h3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_wdata = mk(OP_HALT, 0, 0, 0);
        bus.start = 1'b1; bus.in_bits = 32'hFFFF_FFFF;
        @(posedge clk); #1; lat++;
        bus.prog_we = 1'b0; bus.start = 1'b0;
        while (!bus.done && lat < 400) begin @(posedge clk); #1; lat++; end
        check("busy_ign_latency", lat, elat);
        check("busy_ign_cells",   bus.cells, ec);
        run_and_check("rerun_after_busy", 14, 32'h1);
        check("rerun_xor", bus.cells[8], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
